// File: rtl/ste_dice_pkg.sv
// Shared types, die limits and helpers for the dice roll sequencer.
package ste_dice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROLL   = 3'd1,
        ST_STOP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_REPORT = 3'd4
    } dice_ctrl_state_e;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    // Sum width wide enough for N dice each reporting up to 7.
    function automatic int sum_w(input int n);
        return $clog2(32'd7 * n + 32'd1);
    endfunction

    function automatic logic die_val_bad(input logic [2:0] v);
        return (v < DIE_MIN) || (v > DIE_MAX);
    endfunction

endpackage

// File: rtl/ste_dice_roll_ctrl_if.sv
// Signal bundle between the roll sequencer (slave) and the board logic driving it (master).
interface ste_dice_roll_ctrl_if #(
    parameter int N_DICE = 4
) ();
    localparam int SUM_W = ste_dice_pkg::sum_w(N_DICE);

    logic                  trig_pls_i;
    logic [N_DICE-1:0]     en_mask_i;
    logic [N_DICE-1:0]     done_i;
    logic [N_DICE*3-1:0]   dice_val_i;
    logic [N_DICE-1:0]     roll_o;
    logic                  busy_o;
    logic                  result_valid_o;
    logic [SUM_W-1:0]      sum_o;
    logic                  err_o;

    modport master (
        output trig_pls_i, en_mask_i, done_i, dice_val_i,
        input  roll_o, busy_o, result_valid_o, sum_o, err_o
    );

    modport slave (
        input  trig_pls_i, en_mask_i, done_i, dice_val_i,
        output roll_o, busy_o, result_valid_o, sum_o, err_o
    );
endinterface

// File: rtl/ste_dice_timer.sv
// Loadable down-counter that parks at zero; zero_o flags an expired interval.
module ste_dice_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/ste_dice_roll_ctrl.sv
// Roll sequencer: roll selected dice, stagger their stop, wait for done, report the sum.
// Define STE_DICE_RETRIG_EN to let a trigger during ROLL/STOP restart the roll.
module ste_dice_roll_ctrl
    import ste_dice_pkg::*;
#(
    parameter int N_DICE    = 4,
    parameter int ROLL_CYC  = 16,
    parameter int STOP_GAP  = 4,
    parameter int SETTLE_TO = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    ste_dice_roll_ctrl_if.slave  bus
);
    localparam int SUM_W = sum_w(N_DICE);

    dice_ctrl_state_e  state_q, state_d;
    logic [N_DICE-1:0] mask_q, mask_d;
    logic [N_DICE-1:0] roll_q, roll_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              err_q, err_d;

    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              tmr_zero_s;
    logic              start_s, release_s, report_s, timeout_s, retrig_s;
    logic [N_DICE-1:0] roll_rel_s;
    logic [SUM_W-1:0]  sum_s;
    logic              val_bad_s;

    ste_dice_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_ni   (reset_ni),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .zero_o     (tmr_zero_s)
    );

`ifdef STE_DICE_RETRIG_EN
    assign retrig_s = bus.trig_pls_i;
`else
    assign retrig_s = 1'b0;
`endif

    // Clearing the lowest set bit releases the next die in index order.
    assign roll_rel_s = roll_q & (roll_q - N_DICE'(1'b1));

    // Sum and range check of the dice taking part in this roll.
    always_comb begin
        sum_s     = {SUM_W{1'b0}};
        val_bad_s = 1'b0;
        for (int i = 0; i < N_DICE; i++) begin
            if (mask_q[i]) begin
                sum_s     = sum_s + SUM_W'(bus.dice_val_i[3*i +: 3]);
                val_bad_s = val_bad_s | die_val_bad(bus.dice_val_i[3*i +: 3]);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Next-state logic, timer loads and per-cycle events.
    always_comb begin
        state_d    = state_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = {CNT_W{1'b0}};
        start_s    = 1'b0;
        release_s  = 1'b0;
        report_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.trig_pls_i && (bus.en_mask_i != {N_DICE{1'b0}})) begin
                    state_d    = ST_ROLL;
                    start_s    = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(ROLL_CYC - 32'sd1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROLL, ST_STOP: begin
                if (retrig_s) begin
                    state_d    = ST_ROLL;
                    start_s    = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(ROLL_CYC - 32'sd1);
                end else if (tmr_zero_s) begin
                    release_s  = 1'b1;
                    tmr_load_s = 1'b1;
                    if (roll_rel_s == {N_DICE{1'b0}}) begin
                        state_d   = ST_SETTLE;
                        tmr_val_s = CNT_W'(SETTLE_TO - 32'sd1);
                    end else begin
                        state_d   = ST_STOP;
                        tmr_val_s = CNT_W'(STOP_GAP - 32'sd1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if ((bus.done_i & mask_q) == mask_q) begin
                    state_d  = ST_REPORT;
                    report_s = 1'b1;
                end else if (tmr_zero_s) begin
                    state_d   = ST_REPORT;
                    report_s  = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output next values driven from the events above.
    always_comb begin
        mask_d = mask_q;
        roll_d = roll_q;
        rv_d   = 1'b0;
        sum_d  = sum_q;
        err_d  = err_q;
        busy_d = (state_d != ST_IDLE);
        if (start_s) begin
            mask_d = (bus.en_mask_i != {N_DICE{1'b0}}) ? bus.en_mask_i : mask_q;
            roll_d = mask_d;
            err_d  = 1'b0;
        end else if (release_s) begin
            roll_d = roll_rel_s;
        end else if (report_s) begin
            rv_d  = 1'b1;
            sum_d = sum_s;
            err_d = err_q | timeout_s | val_bad_s;
        end else begin
            roll_d = roll_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            mask_q  <= {N_DICE{1'b0}};
            roll_q  <= {N_DICE{1'b0}};
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            sum_q   <= {SUM_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            roll_q  <= roll_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign bus.roll_o         = roll_q;
    assign bus.busy_o         = busy_q;
    assign bus.result_valid_o = rv_q;
    assign bus.sum_o          = sum_q;
    assign bus.err_o          = err_q;
endmodule

// File: tb/tb_ste_dice_roll_ctrl.sv
// Randomized bench for ste_dice_roll_ctrl against a timeline model of the roll sequence.
module tb_ste_dice_roll_ctrl;
    import ste_dice_pkg::*;

    localparam int N  = 4;
    localparam int RC = 16;
    localparam int SG = 4;
    localparam int ST = 8;
    localparam int CW = 8;
`ifdef STE_DICE_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   sum_m = 0;
    logic err_m = 1'b0;

    ste_dice_roll_ctrl_if #(.N_DICE(N)) bus ();

    ste_dice_roll_ctrl #(
        .N_DICE(N), .ROLL_CYC(RC), .STOP_GAP(SG), .SETTLE_TO(ST), .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic logic [3:0] lowbit(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return 4'(1 << i);
        return 4'd0;
    endfunction

    // Roll pattern k cycles after a trigger (base) with mask mk: all on for RC cycles,
    // then one more die stops every SG cycles, lowest index first.
    function automatic logic [3:0] exp_roll(input int k, input int base, input logic [3:0] mk);
        logic [3:0] r = mk;
        int nrel;
        if (k <= base + RC) return mk;
        nrel = (k - base - RC - 1) / SG + 1;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && nrel > 0) begin
                r[i] = 1'b0;
                nrel--;
            end
        end
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_roll"}, 32'(bus.roll_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.result_valid_o), 32'd0);
        check_eq({tag, "_sum"}, 32'(bus.sum_o), 32'(sum_m));
        check_eq({tag, "_err"}, 32'(err_m), 32'(bus.err_o));
    endtask

    task automatic do_roll(input logic [3:0] m, input logic [11:0] vals, input int delay,
                           input int rt, input logic [3:0] en_chg, input bit trig_rep);
        int base2, s0_old, s0, rep, esum;
        logic [3:0] m2, en_rt, r;
        logic eerr;
        s0_old = RC + 1 + (popc(m) - 1) * SG;
        en_rt  = (rt >= 2) ? en_chg : m;
        if (RETRIG && rt >= 1 && rt < s0_old) begin
            base2 = rt;
            m2    = (en_rt != 4'd0) ? en_rt : m;
        end else begin
            base2 = -1;
            m2    = m;
        end
        s0 = ((base2 >= 0) ? base2 : 0) + RC + 1 + (popc(m2) - 1) * SG;
        if (delay < ST) begin
            rep  = s0 + delay + 1;
            eerr = 1'b0;
        end else begin
            rep  = s0 + ST;
            eerr = 1'b1;
        end
        esum = 0;
        for (int i = 0; i < N; i++) begin
            if (m2[i]) begin
                esum += int'(vals[3*i +: 3]);
                if (vals[3*i +: 3] == 3'd0 || vals[3*i +: 3] == 3'd7) eerr = 1'b1;
            end
        end

        @(negedge clk);
        bus.en_mask_i  = m;
        bus.dice_val_i = vals;
        bus.done_i     = 4'd0;
        bus.trig_pls_i = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= rep + 1; k++) begin
            r = (base2 >= 0 && k > base2) ? exp_roll(k, base2, m2) : exp_roll(k, 0, m);
            check_eq("roll", 32'(bus.roll_o), 32'(r));
            check_eq("busy", 32'(bus.busy_o), 32'(k <= rep));
            check_eq("valid", 32'(bus.result_valid_o), 32'(k == rep));
            if (k == 1) begin
                check_eq("err_clr", 32'(bus.err_o), 32'd0);
                check_eq("sum_hold", 32'(bus.sum_o), 32'(sum_m));
            end
            if (k >= rep) begin
                check_eq("sum", 32'(bus.sum_o), 32'(esum));
                check_eq("err", 32'(bus.err_o), 32'(eerr));
            end
            bus.trig_pls_i = 1'b0;
            if (k == 2) bus.en_mask_i = en_chg;
            if (k == rt) bus.trig_pls_i = 1'b1;
            if (trig_rep && k == rep) begin
                bus.en_mask_i  = m;
                bus.trig_pls_i = 1'b1;
            end
            if (k >= s0 && k < rep)
                bus.done_i = (k >= s0 + delay) ? 4'hF : (4'($urandom) & ~lowbit(m2));
            else
                bus.done_i = 4'd0;
            @(negedge clk);
        end
        bus.trig_pls_i = 1'b0;
        bus.done_i     = 4'd0;
        sum_m = esum;
        err_m = eerr;
    endtask

    initial begin
        bus.trig_pls_i = 1'b0;
        bus.en_mask_i  = 4'd0;
        bus.done_i     = 4'd0;
        bus.dice_val_i = 12'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_ni = 1'b1;

        // Full mask, values 3,5,6,1, done two cycles into SETTLE.
        do_roll(4'b1111, {3'd1, 3'd6, 3'd5, 3'd3}, 2, -1, 4'b1111, 1'b0);

        // Trigger with empty mask is ignored.
        @(negedge clk);
        bus.en_mask_i  = 4'd0;
        bus.trig_pls_i = 1'b1;
        @(negedge clk);
        bus.trig_pls_i = 1'b0;
        repeat (3) begin
            check_idle_outputs("zmask");
            @(negedge clk);
        end

        // Sparse mask, unmasked dice carry junk.
        do_roll(4'b0101, {3'(4'($urandom)), 3'd4, 3'(4'($urandom)), 3'd2}, 1, -1, 4'b0000, 1'b0);
        // done never arrives: timeout with error.
        do_roll(4'b1111, {3'd2, 3'd2, 3'd2, 3'd2}, 99, -1, 4'b1111, 1'b0);
        // Trigger mid-roll with en_mask dropped to zero; trigger during REPORT.
        do_roll(4'b1111, {3'd6, 3'd6, 3'd6, 3'd6}, 0, 10, 4'b0000, 1'b1);
        // Trigger mid-roll with a new mask.
        do_roll(4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}, ST - 1, 10, 4'b0110, 1'b0);

        // Reset asserted during STOP.
        @(negedge clk);
        bus.en_mask_i  = 4'b1111;
        bus.trig_pls_i = 1'b1;
        @(negedge clk);
        bus.trig_pls_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            check_eq("rst_roll", 32'(bus.roll_o), 32'(exp_roll(k, 0, 4'b1111)));
            if (k == 20) reset_ni = 1'b0;
            @(negedge clk);
        end
        sum_m = 0;
        err_m = 1'b0;
        check_idle_outputs("midrst");
        reset_ni = 1'b1;
        do_roll(4'b1010, {3'd5, 3'd3, 3'd4, 3'd1}, 3, -1, 4'b0001, 1'b0);

        // Randomized rolls.
        for (int n = 0; n < 12; n++) begin
            logic [3:0] m;
            m = 4'($urandom_range(15, 1));
            do_roll(m, 12'($urandom), int'($urandom_range(ST + 2, 0)),
                    ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 1)) : -1,
                    4'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
